lif_array: RTL
==============

# lif_array

Parametrised array of leaky integrate-and-fire neurons that replaces the single fixed-width LIF neuron in the Tiny Tapeout top level. It holds N_CH independent membrane potentials and advances all of them on a shared `step` strobe. Runtime inputs set the threshold, the leak rate, the refractory length and the post-spike reset mode. A saturating counter accumulates the total number of spikes for readout.

## Interface
- N_CH, 4: number of neuron channels (1..8)
- W, 8: membrane and current width in bits (4..16)
- RW, 3: refractory counter width in bits
- CW, 16: spike counter width in bits

- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- step  in  1  update strobe; all channels advance on a clk edge where step=1
- current  in  N_CH*W  per-channel input current, unsigned; channel i occupies [i*W +: W]
- threshold  in  W  firing threshold, unsigned, shared by all channels
- leak_shift  in  3  leak amount, decay = v >> leak_shift; value 0 disables leak
- refrac_len  in  RW  number of steps a channel ignores after it spikes
- reset_mode  in  1  post-spike reset: 0 = set v to 0, 1 = v minus threshold
- clr_count  in  1  synchronous clear of spike_count
- state  out  N_CH*W  per-channel membrane potential, registered
- spike  out  N_CH  per-channel spike, a one-cycle registered pulse
- spike_count  out  CW  total number of spikes, saturating

## Operation
- Reset (rst_n=0) acts immediately and clears every register: state=0, spike=0, all refractory counters=0, spike_count=0.
- On a cycle without step, state, spike, counters and spike_count all hold. Exceptions: spike is forced to 0, and clr_count still applies.
- Step update for each channel i (v = its current state, r = its refractory counter):
  - If r>0: r <= r-1. v holds and current is ignored. spike[i] <= 0.
  - If r=0: decay = (leak_shift==0) ? 0 : v >> leak_shift.
  - sum = v - decay + current[i], computed in W+1 bits and clipped to 2^W-1.
  - If sum >= threshold: spike[i] <= 1, r <= refrac_len, v <= (reset_mode ? sum - threshold : 0).
  - Otherwise: spike[i] <= 0 and v <= sum.
- threshold=0: every non-refractory step fires.
- refrac_len=0: no refractory period.
- Config inputs (threshold, leak_shift, refrac_len, reset_mode) are sampled only on step edges. They may change between steps without any glitch on the outputs.
- spike_count:
  - On a step edge, it adds the popcount of the spike vector being registered on that edge, and saturates at 2^CW-1.
  - If clr_count=1 on any edge, spike_count <= 0. clr_count takes priority over a simultaneous add.
- Channels are fully independent; only the config inputs and the counter are shared.

## Timing
- Update latency is one cycle. The new state and spike appear on the clk edge that sampled step=1.
- spike is high for exactly one cycle after a step edge. Back-to-back steps can produce consecutive high cycles.
- spike_count reflects that edge's spikes on the same edge as spike.
- rst_n assertion mid-operation clears all outputs asynchronously. Deassertion is synchronised externally; the first step after release starts from v=0 and r=0.
- Throughput is one step per clock. There is no handshake and no busy state.

## Test plan
- Reset: assert rst_n=0 mid-run with nonzero states -> state=0, spike=0 and spike_count=0 immediately; all hold at 0 with step=0 after release.
- Integration: N_CH=4, W=8, ch0 current=50, threshold=200, leak_shift=0, reset_mode=0; 4 steps -> state 50, 100, 150, then spike[0]=1 and state=0; spike_count=1.
- Leak: leak_shift=1, current=100 for one step, then current=0 for 7 steps -> state 100, 50, 25, 13, 7, 4, 2, 1. Hold at 1 for further steps.
- Saturation and subtract: threshold=255, reset_mode=1, current=200 -> step 1: state=200; step 2: sum clipped to 255, spike, state=0.
- Refractory: refrac_len=2, current=255, threshold=100, reset_mode=0 -> spike on step 1; steps 2–3 have no spike and state=0; step 4 spikes again.
- Counter: all 4 channels current=150, threshold=100, reset_mode=1 -> step 1: all spike, state=50, count=4; step 2: all spike, state=100, count=8. clr_count=1 together with step 3 -> count=0. With CW=3, spikes beyond 7 hold the count at 7.

Source files
------------

// File: rtl/lif_array.sv
// lif_array: N_CH leaky integrate-and-fire neurons advanced together on a shared step strobe
module lif_array #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int RW   = 3,
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [N_CH*W-1:0] current,
    input  logic [W-1:0]      threshold,
    input  logic [2:0]        leak_shift,
    input  logic [RW-1:0]     refrac_len,
    input  logic              reset_mode,
    input  logic              clr_count,
    output logic [N_CH*W-1:0] state,
    output logic [N_CH-1:0]   spike,
    output logic [CW-1:0]     spike_count
);
    logic [W-1:0]    r_v [N_CH];
    logic [RW-1:0]   r_r [N_CH];
    logic [N_CH-1:0] r_spike;
    logic [CW-1:0]   r_count;
    logic [W-1:0]    w_next_v [N_CH];
    logic [RW-1:0]   w_next_r [N_CH];
    logic [N_CH-1:0] w_fire;
    logic [3:0]      w_pop;
    logic [CW+3:0]   w_add;
    logic [CW-1:0]   w_next_count;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            logic [W-1:0] w_decay;
            logic [W:0]   w_sum;
            logic [W-1:0] w_clip;
            logic         w_idle;
            assign w_idle      = (r_r[g] == '0);
            assign w_decay     = (leak_shift == 3'd0) ? '0 : r_v[g] >> leak_shift;
            assign w_sum       = {1'b0, r_v[g] - w_decay} + {1'b0, current[g*W +: W]};
            assign w_clip      = w_sum[W] ? '1 : w_sum[W-1:0];
            assign w_fire[g]   = w_idle && (w_clip >= threshold);
            assign w_next_v[g] = !w_idle ? r_v[g] : w_fire[g] ? (reset_mode ? w_clip - threshold : '0) : w_clip;
            assign w_next_r[g] = !w_idle ? r_r[g] - RW'(1) : w_fire[g] ? refrac_len : '0;
            assign state[g*W +: W] = r_v[g];
        end
    endgenerate

    // count how many channels fire on this step
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_CH; i++) w_pop = w_pop + {3'b000, w_fire[i]};
    end

    assign w_add        = {4'b0000, r_count} + {{CW{1'b0}}, w_pop};
    assign w_next_count = (w_add > {4'b0000, {CW{1'b1}}}) ? '1 : w_add[CW-1:0];

    // membrane potentials and refractory counters advance only on step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_v[i] <= '0;
                r_r[i] <= '0;
            end
        end else if (step) begin
            for (int i = 0; i < N_CH; i++) begin
                r_v[i] <= w_next_v[i];
                r_r[i] <= w_next_r[i];
            end
        end
    end

    // spike is a one-cycle pulse, forced low on cycles without step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_spike <= '0;
        else        r_spike <= step ? w_fire : '0;
    end

    // saturating spike counter; clear wins over a simultaneous add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_count <= '0;
        else if (clr_count) r_count <= '0;
        else if (step)      r_count <= w_next_count;
    end

    assign spike       = r_spike;
    assign spike_count = r_count;
endmodule
